alu_exec_stage: RTL

- Registered, handshaked execute stage wrapping the RV32I integer ALU operation set.
- Accepts operation requests on a valid/ready input channel and computes the result in one cycle.
- Buffers results in a small in-order result queue and presents them on a valid/ready output channel.
- It is the producer side of the a/b/alu_ctrl → result/zero interface; the ALU assertion checker binds to its internal compute signals.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_exec_stage_fifo.sv | 61 ++++++
 rtl/alu_exec_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, default widths and result record.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned TAG_W_DEFAULT = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_ctrl_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]  result;
    logic                     zero;
    logic                     illegal;
    logic [TAG_W_DEFAULT-1:0] tag;
  } alu_result_t;

endpackage

// File: rtl/alu_exec_stage_fifo.sv
// In-order result queue; pointers carry an extra wrap bit for full/empty decode.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wr_data,
  input  logic                   pop,
  output T                       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned IW   = (AW == 0) ? 1 : AW;
  localparam logic [AW:0] WRAP = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  T            mem [DEPTH];
  T            last;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic        do_push;
  logic        do_pop;

  assign wr_idx  = IW'(wr_ptr) & IW'(DEPTH - 1);
  assign rd_idx  = IW'(rd_ptr) & IW'(DEPTH - 1);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == (rd_ptr ^ WRAP));
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // When empty, keep presenting the most recently popped entry.
  assign rd_data = empty ? last : mem[rd_idx];

  // Storage, pointer advance and last-popped capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= wr_data;
        wr_ptr      <= wr_ptr + ONE;
      end
      if (do_pop) begin
        last   <= mem[rd_idx];
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Handshaked RV32I ALU execute stage with an in-order result queue.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [3:0]       in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      illegal_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  function automatic res_t compute(input logic [3:0] ctrl, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    res_t      r;
    alu_ctrl_e op;
    logic [4:0] sh;
    r  = '0;
    op = alu_ctrl_e'(ctrl);
    sh = b[4:0];
    case (op)
      ALU_ADD:  r.result = a + b;
      ALU_SUB:  r.result = a - b;
      ALU_SLL:  r.result = a << sh;
      ALU_SLT:  r.result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: r.result = XLEN'(a < b);
      ALU_XOR:  r.result = a ^ b;
      ALU_SRL:  r.result = a >> sh;
      ALU_SRA:  r.result = $unsigned($signed(a) >>> sh);
      ALU_OR:   r.result = a | b;
      ALU_AND:  r.result = a & b;
      default:  r.illegal = 1'b1;
    endcase
    r.zero = (r.result == '0);
    r.tag  = tag;
    return r;
  endfunction

  res_t          alu_res;
  res_t          head;
  logic          push;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count;

  assign alu_res  = compute(in_ctrl, in_a, in_b, in_tag);
  // Readiness comes only from registered occupancy, never from out_ready.
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (alu_res),
    .pop     (out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign out_valid   = !empty;
  assign out_result  = head.result;
  assign out_zero    = head.zero;
  assign out_illegal = head.illegal;
  assign out_tag     = head.tag;

  // Saturating count of accepted illegal opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (push && alu_res.illegal && (illegal_count != '1)) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end

  // Occupancy sanity check.
  always_ff @(posedge clk) begin
    if (rst_n) assert (fifo_count <= CW'(DEPTH));
  end

endmodule
